// File: rtl/iterative_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : iterative_multiplier_if
// Description : Handshake/operand bundle for the iterative shift-add
//               multiplier. The master issues start/a/b and observes
//               busy/done/result/multV; the slave is the multiplier itself.
//   start  : request a multiply (master -> slave)
//   a, b   : unsigned multiplicand / multiplier, M bits (master -> slave)
//   busy   : operation iterating (slave -> master)
//   done   : one-cycle pulse, result/multV newly valid (slave -> master)
//   result : low M bits of a*b (slave -> master)
//   multV  : full product does not fit in M bits (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface iterative_multiplier_if #(
  parameter int M = 4
);
  logic         start;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         busy;
  logic         done;
  logic [M-1:0] result;
  logic         multV;

  modport master (
    output start, a, b,
    input  busy, done, result, multV
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, multV
  );
endinterface
`default_nettype wire

// File: rtl/iterative_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : iterative_multiplier
// Description : Multi-cycle unsigned shift-add multiplier. One partial
//               product is accumulated per clock; an M-bit operation takes M
//               iterations followed by a single DONE cycle.
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high reset
//   bus    : slave side of iterative_multiplier_if (start/a/b in,
//            busy/done/result/multV out)
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_multiplier #(
  parameter int M = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  iterative_multiplier_if.slave bus
);

  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [2*M-1:0] mcand;      // multiplicand, widened so left shifts keep every bit
  logic [M-1:0]   mplier;     // multiplier, LSB selects the current partial product
  logic [2*M-1:0] acc;
  logic [2*M-1:0] acc_sum;
  logic [CW-1:0]  cnt;
  logic [M-1:0]   result_q;
  logic           multv_q;
  logic           accept;
  logic           last_iter;

  // A new operation may only be taken when nothing is in flight.
  assign accept    = bus.start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == CW'(M - 1));
  assign acc_sum   = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
      multv_q  <= 1'b0;
    end else if (accept) begin
      mcand  <= {{M{1'b0}}, bus.a};
      mplier <= bus.b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      // Outputs are only touched on the final iteration so partial products
      // never become visible.
      if (last_iter) begin
        result_q <= acc_sum[M-1:0];
        multv_q  <= |acc_sum[2*M-1:M];
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.multV  = multv_q;

endmodule
`default_nettype wire

// File: tb/tb_iterative_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_multiplier
// Description : Self-checking bench for iterative_multiplier. A driver issues
//               directed and random multiplies and pushes the expected
//               product into a scoreboard; an independent monitor pops and
//               compares on every done pulse and checks output holding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_multiplier;

  localparam int M = 4;

  typedef struct {
    logic [M-1:0] r;
    logic         v;
  } exp_t;

  logic clk;
  logic reset;

  iterative_multiplier_if #(.M(M)) bus ();

  iterative_multiplier #(.M(M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  logic [M-1:0] hold_r = '0;
  logic         hold_v = 1'b0;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer multiply, split into low word and overflow flag.
  function automatic exp_t model(input int unsigned a, input int unsigned b);
    exp_t e;
    int unsigned p;
    p   = a * b;
    e.r = M'(p % (1 << M));
    e.v = (p >= (1 << M));
    return e;
  endfunction

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (bus.done) begin
          chk("done_busy_excl", int'(bus.busy), 0);
          if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("result", int'(bus.result), int'(e.r));
            chk("multV", int'(bus.multV), int'(e.v));
            hold_r = e.r;
            hold_v = e.v;
          end
        end else begin
          chk("hold_result", int'(bus.result), int'(hold_r));
          chk("hold_multV", int'(bus.multV), int'(hold_v));
        end
      end
    end
  end

  // All driver activity happens 1 time unit after a rising edge. The caller
  // guarantees the DUT is in IDLE or DONE on entry.
  task automatic run_op(input int unsigned a, input int unsigned b,
                        input bit junk, input int rst_iter);
    bus.start = 1'b1;
    bus.a     = M'(a);
    bus.b     = M'(b);
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < M; i++) begin
      chk("busy_run", int'(bus.busy), 1);
      chk("done_run", int'(bus.done), 0);
      if (junk) begin
        bus.start = 1'b1;
        bus.a     = (i == 0) ? M'(7) : M'($urandom_range(0, (1 << M) - 1));
        bus.b     = (i == 0) ? M'(7) : M'($urandom_range(0, (1 << M) - 1));
      end
      if (i == rst_iter) begin
        reset     = 1'b1;
        bus.start = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        hold_r = '0;
        hold_v = 1'b0;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_multV", int'(bus.multV), 0);
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    chk("done_latency", int'(bus.done), 1);
    chk("busy_in_done", int'(bus.busy), 0);
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_result", int'(bus.result), 0);
    chk("reset_multV", int'(bus.multV), 0);
    mon_en = 1'b1;

    run_op(3, 2, 1'b0, -1);
    idle(2);
    run_op(5, 4, 1'b0, -1);
    idle(1);
    run_op(15, 15, 1'b0, -1);
    idle(1);
    run_op(0, 13, 1'b0, -1);
    idle(1);
    run_op(15, 1, 1'b0, -1);
    idle(1);
    run_op(3, 3, 1'b1, -1);
    idle(M + 2);
    // Back-to-back: second start is presented during the DONE cycle.
    run_op(5, 3, 1'b0, -1);
    run_op(2, 7, 1'b0, -1);
    idle(1);
    run_op(9, 11, 1'b0, 1);
    idle(M + 2);
    run_op(6, 2, 1'b0, -1);
    idle(1);

    repeat (30) begin
      run_op($urandom_range(0, (1 << M) - 1), $urandom_range(0, (1 << M) - 1),
             ($urandom_range(0, 3) == 0), -1);
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
